mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, datapath width (32 or 64 only); ADDR_W, default 32, byte address width; REG_ADDR_W, default 5, register index width.
REQ-002 SHALL have ports, clock and reset first (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX/MEM slot holds an instruction.
- ex_mem_re / ex_mem_we  in  1  load / store.
- ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only).
- ex_mem_signed  in  1  sign-extend load.
- ex_mem_addr  in  ADDR_W  byte address.
- ex_store_data  in  DATA_W  store source.
- ex_alu_result  in  DATA_W  non-load writeback value.
- ex_regfile_we  in  1  write enable.
- ex_regfile_waddr  in  REG_ADDR_W  destination.
- mem_stall  out  1  upstream holds EX/MEM when high.
- dm_req, dm_we  out  1  memory request, write.
- dm_addr  out  ADDR_W  lane-aligned address (low log2(DATA_W/8) bits zero).
- dm_be  out  DATA_W/8  byte enables.
- dm_wdata  out  DATA_W  write data.
- dm_rdata  in  DATA_W  read data, valid with dm_ack.
- dm_ack  in  1  one-cycle completion.
- wb_valid, wb_regfile_we  out  1  MEM/WB slot valid, write enable.
- wb_regfile_addr  out  REG_ADDR_W  destination.
- wb_data  out  DATA_W  writeback value.
- misalign_exc  out  1  misaligned access flag, with wb_valid.

Function
REQ-003 SHALL implement FSM IDLE, BUSY; all wb_* and dm_* outputs registered.
REQ-004 Memory op = ex_valid & (ex_mem_re | ex_mem_we); ex_mem_we has priority when both set (store, no writeback).
REQ-005 Misaligned = half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0, or size 11 when DATA_W=32; SHALL issue no dm_req, and next cycle give wb_valid=1, wb_regfile_we=0, misalign_exc=1; no stall.
REQ-006 IDLE, non-memory ex_valid: next cycle wb_valid=1, wb_regfile_we/addr copied, wb_data=ex_alu_result; mem_stall=0.
REQ-007 IDLE, aligned memory op: mem_stall=1 combinationally; latch op; next cycle state=BUSY, dm_req=1, wb_valid=0.
REQ-008 BUSY: dm_req, dm_we, dm_addr, dm_be, dm_wdata SHALL stay stable until dm_ack; ex_* ignored; wb_valid=0.
REQ-009 mem_stall = (IDLE & aligned memory op) | (BUSY & ~dm_ack); deasserts in the dm_ack cycle so upstream advances at that edge.
REQ-010 On dm_ack in BUSY: dm_req drops next cycle, state->IDLE, wb_valid=1 next cycle; load: wb_regfile_we=latched we, wb_data=extracted value; store: wb_regfile_we=0.
REQ-011 Store: dm_be set for bytes addressed by size at addr low bits; dm_wdata = store data replicated across lanes.
REQ-012 Load: extract addressed lane from dm_rdata; zero- or sign-extend to DATA_W per ex_mem_signed.
REQ-013 Memory latency = ack cycle + 1; minimum 3 cycles (accept, req, ack same cycle as req => wb next).
REQ-014 dm_ack outside BUSY SHALL be ignored.

Reset
REQ-015 rst low SHALL immediately force state=IDLE and every output to 0, including mid-transaction (dm_req drops asynchronously; outstanding ack later ignored).
REQ-016 First edge after rst release SHALL behave as IDLE.

Structure
REQ-017 Package mem_pkg SHALL hold size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the FSM state enum.
REQ-018 Combinational sub-module mem_lane_align SHALL compute dm_be, replicated wdata, misalignment, and load extract/extend.

Verification
REQ-019 Load byte signed, addr 0x103, dm_rdata 0x80_00_00_00, ack 2 cycles after req -> wb_data 0xFFFFFF80, wb_valid 1 cycle, mem_stall high accept-cycle to before ack.
REQ-020 Store half, addr 0x102, data 0x0000BEEF -> dm_be 4'b1100, dm_wdata 0xBEEFBEEF, dm_addr 0x100, wb_regfile_we 0.
REQ-021 Load word addr 0x101 -> no dm_req, misalign_exc=1, wb_regfile_we=0, mem_stall 0.
REQ-022 Back-to-back ALU ops -> wb_data tracks ex_alu_result at 1-cycle latency, no stall, wb_valid continuous.
REQ-023 rst low while BUSY with dm_ack pending -> dm_req 0 immediately; late dm_ack produces no wb_valid.
REQ-024 DATA_W=64, load dword addr 0x08, ex_mem_signed=0 -> dm_be 8'hFF, wb_data = dm_rdata.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes and FSM states.
package mem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } lsu_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for the LSU: byte enables, store-data replication, misalignment
// detection on the request side, and lane extraction with extension on the load side.
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [1:0]                     size,
   input  logic [$clog2(DATA_W/8)-1:0]    offset,
   input  logic [DATA_W-1:0]              store_data,
   output logic [DATA_W/8-1:0]            be_c,
   output logic [DATA_W-1:0]              wdata_c,
   output logic                           misalign_c,
   input  logic [1:0]                     ld_size,
   input  logic                           ld_signed,
   input  logic [$clog2(DATA_W/8)-1:0]    ld_offset,
   input  logic [DATA_W-1:0]              rdata,
   output logic [DATA_W-1:0]              ld_data_c
);

   localparam int unsigned BE_W = DATA_W / 8;

   logic [2:0]        off3;
   logic [BE_W-1:0]   be_mask;
   logic [DATA_W-1:0] shifted;

   assign off3 = 3'(offset);

   // Request side: enable mask by size, replicate the low bits of store data.
   always_comb begin
      be_mask    = '0;
      wdata_c    = store_data;
      misalign_c = 1'b0;
      case (size)
         SZ_B: begin
            be_mask = BE_W'(8'h01);
            wdata_c = {BE_W{store_data[7:0]}};
         end
         SZ_H: begin
            be_mask    = BE_W'(8'h03);
            wdata_c    = {(DATA_W/16){store_data[15:0]}};
            misalign_c = off3[0];
         end
         SZ_W: begin
            be_mask    = BE_W'(8'h0F);
            wdata_c    = {(DATA_W/32){store_data[31:0]}};
            misalign_c = |off3[1:0];
         end
         default: begin
            be_mask    = BE_W'(8'hFF);
            wdata_c    = store_data;
            misalign_c = (DATA_W == 32) || (|off3);
         end
      endcase
   end

   assign be_c    = be_mask << offset;
   assign shifted = rdata >> {ld_offset, 3'b000};

   // Load side: pick the addressed lane and widen it.
   always_comb begin
      ld_data_c = shifted;
      case (ld_size)
         SZ_B: ld_data_c = ld_signed ? DATA_W'($signed(shifted[7:0]))
                                     : DATA_W'(shifted[7:0]);
         SZ_H: ld_data_c = ld_signed ? DATA_W'($signed(shifted[15:0]))
                                     : DATA_W'(shifted[15:0]);
         SZ_W: ld_data_c = ld_signed ? DATA_W'($signed(shifted[31:0]))
                                     : DATA_W'(shifted[31:0]);
         default: ld_data_c = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: passes ALU results through and runs one blocking data-memory
// transaction at a time, stalling upstream until the memory acknowledges.
module mem_stage_lsu
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ex_valid,
   input  logic                   ex_mem_re,
   input  logic                   ex_mem_we,
   input  logic [1:0]             ex_mem_size,
   input  logic                   ex_mem_signed,
   input  logic [ADDR_W-1:0]      ex_mem_addr,
   input  logic [DATA_W-1:0]      ex_store_data,
   input  logic [DATA_W-1:0]      ex_alu_result,
   input  logic                   ex_regfile_we,
   input  logic [REG_ADDR_W-1:0]  ex_regfile_waddr,
   output logic                   mem_stall,
   output logic                   dm_req,
   output logic                   dm_we,
   output logic [ADDR_W-1:0]      dm_addr,
   output logic [DATA_W/8-1:0]    dm_be,
   output logic [DATA_W-1:0]      dm_wdata,
   input  logic [DATA_W-1:0]      dm_rdata,
   input  logic                   dm_ack,
   output logic                   wb_valid,
   output logic                   wb_regfile_we,
   output logic [REG_ADDR_W-1:0]  wb_regfile_addr,
   output logic [DATA_W-1:0]      wb_data,
   output logic                   misalign_exc
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BE_W - 1);

   lsu_state_e            state;
   logic [1:0]            ld_size;
   logic                  ld_signed;
   logic [OFF_W-1:0]      ld_offset;
   logic                  ld_rf_we;
   logic                  ld_store;
   logic [REG_ADDR_W-1:0] ld_waddr;

   logic [BE_W-1:0]       lane_be;
   logic [DATA_W-1:0]     lane_wdata;
   logic                  lane_misalign;
   logic [DATA_W-1:0]     lane_ld_data;
   logic                  mem_op;
   logic                  accept;

   mem_lane_align #(.DATA_W(DATA_W)) u_align (
      .size       (ex_mem_size),
      .offset     (ex_mem_addr[OFF_W-1:0]),
      .store_data (ex_store_data),
      .be_c       (lane_be),
      .wdata_c    (lane_wdata),
      .misalign_c (lane_misalign),
      .ld_size    (ld_size),
      .ld_signed  (ld_signed),
      .ld_offset  (ld_offset),
      .rdata      (dm_rdata),
      .ld_data_c  (lane_ld_data)
   );

   assign mem_op = ex_valid & (ex_mem_re | ex_mem_we);
   assign accept = mem_op & ~lane_misalign;

   // Released in the ack cycle so upstream advances on the same edge the result lands.
   assign mem_stall = rst & (((state == ST_IDLE) & accept) |
                             ((state == ST_BUSY) & ~dm_ack));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= ST_IDLE;
         dm_req          <= 1'b0;
         dm_we           <= 1'b0;
         dm_addr         <= '0;
         dm_be           <= '0;
         dm_wdata        <= '0;
         wb_valid        <= 1'b0;
         wb_regfile_we   <= 1'b0;
         wb_regfile_addr <= '0;
         wb_data         <= '0;
         misalign_exc    <= 1'b0;
         ld_size         <= SZ_B;
         ld_signed       <= 1'b0;
         ld_offset       <= '0;
         ld_rf_we        <= 1'b0;
         ld_store        <= 1'b0;
         ld_waddr        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               wb_valid      <= 1'b0;
               wb_regfile_we <= 1'b0;
               misalign_exc  <= 1'b0;
               if (mem_op && lane_misalign) begin
                  wb_valid        <= 1'b1;
                  wb_regfile_addr <= ex_regfile_waddr;
                  wb_data         <= '0;
                  misalign_exc    <= 1'b1;
               end else if (mem_op) begin
                  // Store wins when both read and write are flagged.
                  state     <= ST_BUSY;
                  dm_req    <= 1'b1;
                  dm_we     <= ex_mem_we;
                  dm_addr   <= ex_mem_addr & ADDR_MASK;
                  dm_be     <= lane_be;
                  dm_wdata  <= lane_wdata;
                  ld_size   <= ex_mem_size;
                  ld_signed <= ex_mem_signed;
                  ld_offset <= ex_mem_addr[OFF_W-1:0];
                  ld_rf_we  <= ex_regfile_we;
                  ld_store  <= ex_mem_we;
                  ld_waddr  <= ex_regfile_waddr;
               end else if (ex_valid) begin
                  wb_valid        <= 1'b1;
                  wb_regfile_we   <= ex_regfile_we;
                  wb_regfile_addr <= ex_regfile_waddr;
                  wb_data         <= ex_alu_result;
               end
            end
            ST_BUSY: begin
               wb_valid <= 1'b0;
               if (dm_ack) begin
                  state           <= ST_IDLE;
                  dm_req          <= 1'b0;
                  dm_we           <= 1'b0;
                  dm_be           <= '0;
                  wb_valid        <= 1'b1;
                  wb_regfile_we   <= ld_store ? 1'b0 : ld_rf_we;
                  wb_regfile_addr <= ld_waddr;
                  wb_data         <= ld_store ? '0 : lane_ld_data;
                  misalign_exc    <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: table of single transactions on a 32-bit instance with a
// writeback scoreboard, plus hand sequences for streaming, reset and the 64-bit datapath.
module tb_mem_stage_lsu;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 32-bit instance
   logic        ex_valid, ex_mem_re, ex_mem_we, ex_mem_signed, ex_regfile_we;
   logic [1:0]  ex_mem_size;
   logic [31:0] ex_mem_addr, ex_store_data, ex_alu_result;
   logic [4:0]  ex_regfile_waddr;
   logic        mem_stall, dm_req, dm_we, dm_ack;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;
   logic        wb_valid, wb_regfile_we, misalign_exc;
   logic [4:0]  wb_regfile_addr;
   logic [31:0] wb_data;

   // 64-bit instance
   logic        ex_valid_64, ex_mem_re_64, ex_mem_signed_64;
   logic [1:0]  ex_mem_size_64;
   logic [31:0] ex_mem_addr_64;
   logic [63:0] ex_store_data_64, ex_alu_result_64;
   logic        mem_stall_64, dm_req_64, dm_we_64, dm_ack_64;
   logic [31:0] dm_addr_64;
   logic [63:0] dm_wdata_64, dm_rdata_64;
   logic [7:0]  dm_be_64;
   logic        wb_valid_64, wb_regfile_we_64, misalign_exc_64;
   logic [4:0]  wb_regfile_addr_64;
   logic [63:0] wb_data_64;

   mem_stage_lsu dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
      .ex_mem_size(ex_mem_size), .ex_mem_signed(ex_mem_signed), .ex_mem_addr(ex_mem_addr),
      .ex_store_data(ex_store_data), .ex_alu_result(ex_alu_result),
      .ex_regfile_we(ex_regfile_we), .ex_regfile_waddr(ex_regfile_waddr),
      .mem_stall(mem_stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .wb_valid(wb_valid), .wb_regfile_we(wb_regfile_we), .wb_regfile_addr(wb_regfile_addr),
      .wb_data(wb_data), .misalign_exc(misalign_exc)
   );

   mem_stage_lsu #(.DATA_W(64)) dut64 (
      .clk(clk), .rst(rst), .ex_valid(ex_valid_64), .ex_mem_re(ex_mem_re_64), .ex_mem_we(1'b0),
      .ex_mem_size(ex_mem_size_64), .ex_mem_signed(ex_mem_signed_64),
      .ex_mem_addr(ex_mem_addr_64), .ex_store_data(ex_store_data_64),
      .ex_alu_result(ex_alu_result_64), .ex_regfile_we(1'b1), .ex_regfile_waddr(5'd1),
      .mem_stall(mem_stall_64), .dm_req(dm_req_64), .dm_we(dm_we_64), .dm_addr(dm_addr_64),
      .dm_be(dm_be_64), .dm_wdata(dm_wdata_64), .dm_rdata(dm_rdata_64), .dm_ack(dm_ack_64),
      .wb_valid(wb_valid_64), .wb_regfile_we(wb_regfile_we_64),
      .wb_regfile_addr(wb_regfile_addr_64), .wb_data(wb_data_64),
      .misalign_exc(misalign_exc_64)
   );

   typedef struct {
      string       name;
      logic        re, we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr, sdata, alu;
      logic        rfwe;
      logic [4:0]  waddr;
      logic [31:0] rdata;
      int          dly;
      logic        exp_mis;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic        exp_wbwe;
      logic [31:0] exp_wbdata;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] data;
      logic        mis;
      logic        chk_data;
   } wb_t;

   vec_t vecs[$];
   wb_t  sb[$];
   wb_t  mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input string n, input logic re, input logic we,
                               input logic [1:0] sz, input logic sg, input logic [31:0] a,
                               input logic [31:0] sd, input logic [31:0] alu, input logic rfwe,
                               input logic [4:0] wa, input logic [31:0] rd, input int dly,
                               input logic mis, input logic [3:0] be, input logic [31:0] wd,
                               input logic wbwe, input logic [31:0] wbd);
      vec_t v;
      v.name = n; v.re = re; v.we = we; v.size = sz; v.sgn = sg; v.addr = a;
      v.sdata = sd; v.alu = alu; v.rfwe = rfwe; v.waddr = wa; v.rdata = rd; v.dly = dly;
      v.exp_mis = mis; v.exp_be = be; v.exp_wdata = wd; v.exp_wbwe = wbwe; v.exp_wbdata = wbd;
      return v;
   endfunction

   // Writeback scoreboard on the 32-bit instance.
   always @(posedge clk) begin
      #2;
      if (wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("wb_unexpected", 64'(wb_valid), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("wb_regfile_we", 64'(wb_regfile_we), 64'(mon_e.we));
            if (mon_e.we) chk("wb_regfile_addr", 64'(wb_regfile_addr), 64'(mon_e.waddr));
            if (mon_e.chk_data) chk("wb_data", 64'(wb_data), 64'(mon_e.data));
            chk("wb_misalign", 64'(misalign_exc), 64'(mon_e.mis));
         end
      end
   end

   task automatic apply(input vec_t v);
      logic mem, ok;
      wb_t  e;
      mem = v.re | v.we;
      ok  = mem & ~v.exp_mis;
      ex_valid = 1'b1; ex_mem_re = v.re; ex_mem_we = v.we; ex_mem_size = v.size;
      ex_mem_signed = v.sgn; ex_mem_addr = v.addr; ex_store_data = v.sdata;
      ex_alu_result = v.alu; ex_regfile_we = v.rfwe; ex_regfile_waddr = v.waddr;
      #1;
      chk({v.name, "/stall_accept"}, 64'(mem_stall), 64'(ok));
      e.we = v.exp_wbwe; e.waddr = v.waddr; e.data = v.exp_wbdata; e.mis = v.exp_mis;
      e.chk_data = !v.we && !v.exp_mis;
      sb.push_back(e);
      step();
      ex_valid = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0;
      if (ok) begin
         chk({v.name, "/dm_req"}, 64'(dm_req), 64'd1);
         chk({v.name, "/dm_we"}, 64'(dm_we), 64'(v.we));
         chk({v.name, "/dm_addr"}, 64'(dm_addr), 64'({v.addr[31:2], 2'b00}));
         chk({v.name, "/dm_be"}, 64'(dm_be), 64'(v.exp_be));
         if (v.we) chk({v.name, "/dm_wdata"}, 64'(dm_wdata), 64'(v.exp_wdata));
         chk({v.name, "/wb_busy"}, 64'(wb_valid), 64'd0);
         for (int i = 0; i < v.dly; i++) begin
            #1;
            chk({v.name, "/stall_busy"}, 64'(mem_stall), 64'd1);
            step();
            chk({v.name, "/dm_req_hold"}, 64'(dm_req), 64'd1);
            chk({v.name, "/dm_be_hold"}, 64'(dm_be), 64'(v.exp_be));
         end
         dm_ack = 1'b1; dm_rdata = v.rdata;
         #1;
         chk({v.name, "/stall_ack"}, 64'(mem_stall), 64'd0);
         step();
         dm_ack = 1'b0; dm_rdata = '0;
      end
      chk({v.name, "/dm_req_done"}, 64'(dm_req), 64'd0);
      chk({v.name, "/wb_valid"}, 64'(wb_valid), 64'd1);
      step();
      chk({v.name, "/wb_valid_drop"}, 64'(wb_valid), 64'd0);
   endtask

   task automatic apply64(input string n, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [63:0] rd, input logic [31:0] exp_addr,
                          input logic [7:0] exp_be, input logic [63:0] exp_data);
      ex_valid_64 = 1'b1; ex_mem_re_64 = 1'b1; ex_mem_size_64 = sz;
      ex_mem_signed_64 = sg; ex_mem_addr_64 = a;
      #1;
      chk({n, "/stall_accept"}, 64'(mem_stall_64), 64'd1);
      step();
      ex_valid_64 = 1'b0; ex_mem_re_64 = 1'b0;
      chk({n, "/dm_req"}, 64'(dm_req_64), 64'd1);
      chk({n, "/dm_addr"}, 64'(dm_addr_64), 64'(exp_addr));
      chk({n, "/dm_be"}, 64'(dm_be_64), 64'(exp_be));
      #1;
      chk({n, "/stall_busy"}, 64'(mem_stall_64), 64'd1);
      step();
      dm_ack_64 = 1'b1; dm_rdata_64 = rd;
      #1;
      chk({n, "/stall_ack"}, 64'(mem_stall_64), 64'd0);
      step();
      dm_ack_64 = 1'b0; dm_rdata_64 = '0;
      chk({n, "/wb_valid"}, 64'(wb_valid_64), 64'd1);
      chk({n, "/wb_we"}, 64'(wb_regfile_we_64), 64'd1);
      chk({n, "/wb_data"}, wb_data_64, exp_data);
      step();
      chk({n, "/wb_valid_drop"}, 64'(wb_valid_64), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] alu_v;
      wb_t         e;

      vecs.push_back(mk("alu_we", 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b1, 5'd3,
                        32'h0, 0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h12345678));
      vecs.push_back(mk("lb_s_103", 1'b1, 1'b0, SZ_B, 1'b1, 32'h103, 32'h0, 32'h0, 1'b1, 5'd5,
                        32'h80000000, 2, 1'b0, 4'b1000, 32'h0, 1'b1, 32'hFFFFFF80));
      vecs.push_back(mk("sh_102", 1'b0, 1'b1, SZ_H, 1'b0, 32'h102, 32'h0000BEEF, 32'h0, 1'b1, 5'd6,
                        32'h0, 1, 1'b0, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0));
      vecs.push_back(mk("lw_mis_101", 1'b1, 1'b0, SZ_W, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 5'd7,
                        32'h0, 0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0));
      vecs.push_back(mk("lbu_201", 1'b1, 1'b0, SZ_B, 1'b0, 32'h201, 32'h0, 32'h0, 1'b1, 5'd8,
                        32'h0000A500, 0, 1'b0, 4'b0010, 32'h0, 1'b1, 32'h000000A5));
      vecs.push_back(mk("lh_s_202", 1'b1, 1'b0, SZ_H, 1'b1, 32'h202, 32'h0, 32'h0, 1'b1, 5'd9,
                        32'h80010000, 1, 1'b0, 4'b1100, 32'h0, 1'b1, 32'hFFFF8001));
      vecs.push_back(mk("lhu_200", 1'b1, 1'b0, SZ_H, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 5'd10,
                        32'h1234F00D, 0, 1'b0, 4'b0011, 32'h0, 1'b1, 32'h0000F00D));
      vecs.push_back(mk("lw_204", 1'b1, 1'b0, SZ_W, 1'b1, 32'h204, 32'h0, 32'h0, 1'b1, 5'd11,
                        32'hDEADBEEF, 3, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hDEADBEEF));
      vecs.push_back(mk("sb_301", 1'b0, 1'b1, SZ_B, 1'b0, 32'h301, 32'h000000AB, 32'h0, 1'b0, 5'd12,
                        32'h0, 0, 1'b0, 4'b0010, 32'hABABABAB, 1'b0, 32'h0));
      vecs.push_back(mk("sw_308", 1'b0, 1'b1, SZ_W, 1'b0, 32'h308, 32'hCAFEF00D, 32'h0, 1'b0, 5'd13,
                        32'h0, 2, 1'b0, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0));
      vecs.push_back(mk("sh_mis_103", 1'b0, 1'b1, SZ_H, 1'b0, 32'h103, 32'h1234, 32'h0, 1'b0, 5'd14,
                        32'h0, 0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0));
      vecs.push_back(mk("ld_on_32", 1'b1, 1'b0, SZ_D, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 5'd15,
                        32'h0, 0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0));
      vecs.push_back(mk("re_we_both", 1'b1, 1'b1, SZ_B, 1'b0, 32'h400, 32'h11, 32'h0, 1'b1, 5'd16,
                        32'hFFFFFFFF, 0, 1'b0, 4'b0001, 32'h11111111, 1'b0, 32'h0));
      vecs.push_back(mk("lb_norf_402", 1'b1, 1'b0, SZ_B, 1'b1, 32'h402, 32'h0, 32'h0, 1'b0, 5'd17,
                        32'h007F0000, 0, 1'b0, 4'b0100, 32'h0, 1'b0, 32'h0000007F));
      vecs.push_back(mk("alu_nowe", 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 5'd18,
                        32'h0, 0, 1'b0, 4'h0, 32'h0, 1'b0, 32'hA5A5A5A5));

      rst = 1'b0;
      ex_valid = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_mem_size = SZ_B;
      ex_mem_signed = 1'b0; ex_mem_addr = '0; ex_store_data = '0; ex_alu_result = '0;
      ex_regfile_we = 1'b0; ex_regfile_waddr = '0; dm_rdata = '0; dm_ack = 1'b0;
      ex_valid_64 = 1'b0; ex_mem_re_64 = 1'b0; ex_mem_size_64 = SZ_B; ex_mem_signed_64 = 1'b0;
      ex_mem_addr_64 = '0; ex_store_data_64 = '0; ex_alu_result_64 = '0;
      dm_rdata_64 = '0; dm_ack_64 = 1'b0;

      repeat (2) step();
      chk("reset/dm_req", 64'(dm_req), 64'd0);
      chk("reset/dm_be", 64'(dm_be), 64'd0);
      chk("reset/wb_valid", 64'(wb_valid), 64'd0);
      chk("reset/wb_data", 64'(wb_data), 64'd0);
      chk("reset/misalign_exc", 64'(misalign_exc), 64'd0);
      chk("reset/mem_stall", 64'(mem_stall), 64'd0);
      chk("reset/wb_valid_64", 64'(wb_valid_64), 64'd0);
      rst = 1'b1;

      foreach (vecs[i]) apply(vecs[i]);

      // Back-to-back ALU ops stream with no bubbles.
      for (int i = 0; i < 4; i++) begin
         alu_v = $urandom;
         ex_valid = 1'b1; ex_mem_re = 1'b0; ex_mem_we = 1'b0;
         ex_alu_result = alu_v; ex_regfile_we = 1'b1; ex_regfile_waddr = 5'(20 + i);
         #1;
         chk("b2b/stall", 64'(mem_stall), 64'd0);
         e.we = 1'b1; e.waddr = 5'(20 + i); e.data = alu_v; e.mis = 1'b0; e.chk_data = 1'b1;
         sb.push_back(e);
         step();
         chk("b2b/wb_valid", 64'(wb_valid), 64'd1);
      end
      ex_valid = 1'b0;
      step();
      chk("b2b/wb_valid_end", 64'(wb_valid), 64'd0);

      // Stray ack while idle must do nothing.
      dm_ack = 1'b1; dm_rdata = 32'h55555555;
      #1;
      chk("idle_ack/stall", 64'(mem_stall), 64'd0);
      step();
      dm_ack = 1'b0;
      chk("idle_ack/wb_valid", 64'(wb_valid), 64'd0);
      chk("idle_ack/dm_req", 64'(dm_req), 64'd0);

      // Reset mid-transaction, then a late ack.
      ex_valid = 1'b1; ex_mem_re = 1'b1; ex_mem_size = SZ_W; ex_mem_addr = 32'h500;
      ex_regfile_we = 1'b1; ex_regfile_waddr = 5'd2;
      step();
      ex_valid = 1'b0; ex_mem_re = 1'b0;
      chk("rst_busy/dm_req_before", 64'(dm_req), 64'd1);
      rst = 1'b0;
      #1;
      chk("rst_busy/dm_req", 64'(dm_req), 64'd0);
      chk("rst_busy/dm_be", 64'(dm_be), 64'd0);
      chk("rst_busy/mem_stall", 64'(mem_stall), 64'd0);
      step();
      rst = 1'b1;
      dm_ack = 1'b1; dm_rdata = 32'h12345678;
      #1;
      chk("rst_busy/stall_late_ack", 64'(mem_stall), 64'd0);
      step();
      dm_ack = 1'b0;
      chk("rst_busy/wb_valid", 64'(wb_valid), 64'd0);
      step();
      chk("rst_busy/wb_valid_after", 64'(wb_valid), 64'd0);
      chk("rst_busy/dm_req_after", 64'(dm_req), 64'd0);

      // Post-reset the unit still works.
      apply(vecs[1]);

      // 64-bit datapath.
      apply64("ld_08", SZ_D, 1'b0, 32'h08, 64'h0123456789ABCDEF, 32'h08, 8'hFF,
              64'h0123456789ABCDEF);
      apply64("lw_s_0c", SZ_W, 1'b1, 32'h0C, 64'h80000000_00000000, 32'h08, 8'hF0,
              64'hFFFFFFFF_80000000);

      step();
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
